// File: rtl/layer_mac_seq.sv
// ---------------------------------------------------------------------------
// layer_mac_seq: a fully connected layer computed sequentially.
// An input vector of IN_CH signed samples is multiplied by an OUT_CH x IN_CH
// weight matrix. The block walks one input channel per cycle and updates all
// OUT_CH accumulators in parallel. Each sum is then round-shifted by SHIFT,
// optionally clamped at zero (RELU_EN), and saturated to WORD bits.
//
// Ports
//   clk, rst_n      single clock; asynchronous active-low reset
//   i_in_valid      upstream offers a vector
//   o_in_ready      vector accepted this cycle (IDLE, or OUT being drained)
//   i_data          IN_CH samples, channel k at [k*WORD +: WORD]
//   i_weight        weight(o,k) at [(o*IN_CH+k)*WORD +: WORD]
//   o_out_valid     o_data/o_sat hold a result
//   i_out_ready     downstream consumes the result
//   o_data          OUT_CH results, channel o at [o*WORD +: WORD]
//   o_sat           at least one channel of the result was clipped
//   o_busy          accumulating or rounding
// ---------------------------------------------------------------------------

// Per-output-channel datapath: accumulator plus the round/relu/saturate stage.
module layer_mac_lane #(
  parameter int IN_CH   = 8,
  parameter int WORD    = 16,
  parameter int SHIFT   = 3,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   acc_en_i,
  input  logic                   rnd_en_i,
  input  logic signed [WORD-1:0] a_i,
  input  logic signed [WORD-1:0] w_i,
  output logic        [WORD-1:0] data_o,
  output logic                   sat_o
);
  // Sized so IN_CH full-scale products can never overflow.
  localparam int AW = 2*WORD + $clog2(IN_CH);
  localparam int EW = AW - 2*WORD;

  localparam logic signed [AW:0] HALF = (AW+1)'(2**(SHIFT-1));
  localparam logic signed [AW:0] MAXV = {{(AW-WORD+2){1'b0}}, {(WORD-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW-WORD+2){1'b1}}, {(WORD-1){1'b0}}};

  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [2*WORD-1:0] prod;
  logic signed [AW:0]       sum, r, rr;
  logic        [WORD-1:0]   data_q, data_d;
  logic                     sat_q, sat_d;

  assign prod = a_i * w_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + {{EW{prod[2*WORD-1]}}, prod};
  end

  // One guard bit above the accumulator so the rounding add cannot wrap.
  always_comb begin
    sum    = {acc_q[AW-1], acc_q} + HALF;
    r      = sum >>> SHIFT;
    rr     = (RELU_EN && r < 0) ? '0 : r;
    data_d = data_q;
    sat_d  = sat_q;
    if (rnd_en_i) begin
      sat_d = 1'b0;
      if (rr > MAXV) begin
        data_d = MAXV[WORD-1:0];
        sat_d  = 1'b1;
      end else if (rr < MINV) begin
        data_d = MINV[WORD-1:0];
        sat_d  = 1'b1;
      end else begin
        data_d = rr[WORD-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;
endmodule

module layer_mac_seq #(
  parameter int IN_CH   = 8,
  parameter int OUT_CH  = 16,
  parameter int WORD    = 16,
  parameter int SHIFT   = 3,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [WORD*IN_CH-1:0]        i_data,
  input  logic [WORD*OUT_CH*IN_CH-1:0] i_weight,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [WORD*OUT_CH-1:0]       o_data,
  output logic                         o_sat,
  output logic                         o_busy
);
  localparam int KW = $clog2(IN_CH);
  // One extra bit so the counter reaches IN_CH after the last step
  // instead of wrapping back to 0.
  localparam int CW = KW + 1;

  typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_e;

  state_e                                     state_q, state_d;
  logic [CW-1:0]                              cnt_q, cnt_d;
  logic [IN_CH-1:0][WORD-1:0]                 data_q;
  logic [OUT_CH-1:0][IN_CH-1:0][WORD-1:0]     weight_q;
  logic [OUT_CH-1:0]                          lane_sat;
  logic                                       accept, start, acc_en, rnd_en;
  logic [KW-1:0]                              k;

  assign o_in_ready  = (state_q == IDLE) | ((state_q == OUT) & i_out_ready);
  assign accept      = i_in_valid & o_in_ready;
  assign o_out_valid = (state_q == OUT);
  assign o_busy      = (state_q == ACC) | (state_q == RND);
  assign o_sat       = |lane_sat;
  assign k           = cnt_q[KW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    acc_en  = 1'b0;
    rnd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(IN_CH-1)) state_d = RND;
      end
      RND: begin
        rnd_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (accept) begin
          // Draining and accepting on the same edge: no bubble cycle.
          start   = 1'b1;
          cnt_d   = '0;
          state_d = ACC;
        end else if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      weight_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        data_q   <= i_data;
        weight_q <= i_weight;
      end
    end
  end

  for (genvar o = 0; o < OUT_CH; o++) begin : g_lane
    layer_mac_lane #(
      .IN_CH  (IN_CH),
      .WORD   (WORD),
      .SHIFT  (SHIFT),
      .RELU_EN(RELU_EN)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (start),
      .acc_en_i(acc_en),
      .rnd_en_i(rnd_en),
      .a_i     (data_q[k]),
      .w_i     (weight_q[o][k]),
      .data_o  (o_data[o*WORD +: WORD]),
      .sat_o   (lane_sat[o])
    );
  end
endmodule

// File: tb/tb_layer_mac_seq.sv
// Bench for layer_mac_seq: a table of directed vectors plus hand-written
// sequences for output back-pressure, back-to-back accept and reset in ACC.
// A second instance with RELU_EN=1 receives the same stimulus.
module tb_layer_mac_seq;
  localparam int IN_CH  = 8;
  localparam int OUT_CH = 16;
  localparam int WORD   = 16;
  localparam int DW     = WORD*IN_CH;
  localparam int WW     = WORD*OUT_CH*IN_CH;
  localparam int OW     = WORD*OUT_CH;
  localparam int NV     = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_in_valid, i_out_ready;
  logic [DW-1:0] i_data;
  logic [WW-1:0] i_weight;
  logic          o_in_ready, o_out_valid, o_sat, o_busy;
  logic [OW-1:0] o_data;
  logic          r_in_ready, r_out_valid, r_sat, r_busy;
  logic [OW-1:0] r_data;

  always #5 clk = ~clk;

  layer_mac_seq #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .WORD(WORD), .SHIFT(3), .RELU_EN(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_data(i_data), .i_weight(i_weight), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_data(o_data), .o_sat(o_sat), .o_busy(o_busy));

  layer_mac_seq #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .WORD(WORD), .SHIFT(3), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(r_in_ready),
    .i_data(i_data), .i_weight(i_weight), .o_out_valid(r_out_valid),
    .i_out_ready(i_out_ready), .o_data(r_data), .o_sat(r_sat), .o_busy(r_busy));

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic [WW-1:0] weight;
    logic [OW-1:0] exp_data;
    logic          exp_sat;
    logic [OW-1:0] exp_relu;
  } vec_t;

  vec_t vec [NV];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill_d(input logic [WORD-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < IN_CH; k++) r[k*WORD +: WORD] = v;
    return r;
  endfunction

  function automatic logic [OW-1:0] fill_o(input logic [WORD-1:0] v);
    logic [OW-1:0] r;
    for (int o = 0; o < OUT_CH; o++) r[o*WORD +: WORD] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] fill_w(input logic [WORD-1:0] v);
    logic [WW-1:0] r;
    for (int i = 0; i < OUT_CH*IN_CH; i++) r[i*WORD +: WORD] = v;
    return r;
  endfunction

  // Offer a vector at a negedge, wait for it to be taken, then scramble the
  // inputs so any dependence on them after the accept shows up as an error.
  task automatic send(input logic [DW-1:0] d, input logic [WW-1:0] w, input string nm);
    int guard = 0;
    while (!o_in_ready && guard < 100) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    check({nm, " ready before send"}, OW'(o_in_ready), OW'(1));
    i_in_valid = 1'b1; i_data = d; i_weight = w;
    @(posedge clk); @(negedge clk);
    i_in_valid = 1'b0; i_data = ~d; i_weight = ~w;
    check({nm, " busy after accept"}, OW'(o_busy), OW'(1));
  endtask

  // Edges counted from the accept edge (edge 1) up to the one raising o_out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!o_out_valid && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic pop(input string nm);
    i_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    i_out_ready = 1'b0;
    check({nm, " valid after pop"}, OW'(o_out_valid), OW'(0));
  endtask

  initial begin
    int n;
    logic [OW-1:0] e;

    // Table: all ones, positive and negative saturation, rounding, ramp +/-.
    vec[0] = '{"ones", fill_d(16'h0001), fill_w(16'h0001), fill_o(16'h0001), 1'b0, fill_o(16'h0001)};
    vec[1] = '{"satpos", fill_d(16'h7FFF), fill_w(16'h7FFF), fill_o(16'h7FFF), 1'b1, fill_o(16'h7FFF)};
    vec[2] = '{"satneg", fill_d(16'h8000), fill_w(16'h7FFF), fill_o(16'h8000), 1'b1, fill_o(16'h0000)};
    // Only sample 0 is 1; channel sums -4, -5, +12, rest 0.
    vec[3].name = "round";
    vec[3].data = '0; vec[3].data[WORD-1:0] = 16'h0001;
    vec[3].weight = '0;
    vec[3].weight[(0*IN_CH)*WORD +: WORD] = 16'hFFFC;
    vec[3].weight[(1*IN_CH)*WORD +: WORD] = 16'hFFFB;
    vec[3].weight[(2*IN_CH)*WORD +: WORD] = 16'h000C;
    vec[3].exp_data = '0; vec[3].exp_data[WORD +: WORD] = 16'hFFFF; vec[3].exp_data[2*WORD +: WORD] = 16'h0002;
    vec[3].exp_sat = 1'b0;
    vec[3].exp_relu = '0; vec[3].exp_relu[2*WORD +: WORD] = 16'h0002;
    // Data 2, weight(o,*) = +/-o: sum = +/-16*o, result = +/-2*o.
    vec[4].name = "ramp+"; vec[5].name = "ramp-";
    vec[4].data = fill_d(16'h0002); vec[5].data = fill_d(16'h0002);
    vec[4].exp_sat = 1'b0; vec[5].exp_sat = 1'b0;
    vec[5].exp_relu = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      for (int k = 0; k < IN_CH; k++) begin
        vec[4].weight[(o*IN_CH+k)*WORD +: WORD] = WORD'(o);
        vec[5].weight[(o*IN_CH+k)*WORD +: WORD] = WORD'(-o);
      end
      vec[4].exp_data[o*WORD +: WORD] = WORD'(2*o);
      vec[4].exp_relu[o*WORD +: WORD] = WORD'(2*o);
      vec[5].exp_data[o*WORD +: WORD] = WORD'(-2*o);
    end

    rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_data = '0; i_weight = '0;
    #1;
    check("rst ready", OW'(o_in_ready), OW'(1));
    check("rst valid", OW'(o_out_valid), OW'(0));
    check("rst data", o_data, '0);
    check("rst sat", OW'(o_sat), OW'(0));
    check("rst busy", OW'(o_busy), OW'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send(vec[i].data, vec[i].weight, vec[i].name);
      wait_valid(n);
      check({vec[i].name, " latency"}, OW'(n), OW'(IN_CH+2));
      check({vec[i].name, " data"}, o_data, vec[i].exp_data);
      check({vec[i].name, " sat"}, OW'(o_sat), OW'(vec[i].exp_sat));
      check({vec[i].name, " relu data"}, r_data, vec[i].exp_relu);
      pop(vec[i].name);
    end

    // Back-pressure in OUT: output must hold and nothing may be accepted.
    send(vec[1].data, vec[1].weight, "hold");
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      i_in_valid = c[0]; i_data = {4{$urandom}}; i_weight = ~i_weight;
      @(posedge clk); @(negedge clk);
      check("hold ready", OW'(o_in_ready), OW'(0));
      check("hold valid", OW'(o_out_valid), OW'(1));
      check("hold data", o_data, vec[1].exp_data);
      check("hold sat", OW'(o_sat), OW'(1));
    end

    // Drain and accept on the same edge.
    i_out_ready = 1'b1; i_in_valid = 1'b1; i_data = vec[4].data; i_weight = vec[4].weight;
    @(posedge clk); @(negedge clk);
    i_out_ready = 1'b0; i_in_valid = 1'b0; i_data = '1; i_weight = '1;
    check("b2b valid low", OW'(o_out_valid), OW'(0));
    check("b2b busy", OW'(o_busy), OW'(1));
    check("b2b data held", o_data, vec[1].exp_data);
    wait_valid(n);
    check("b2b latency", OW'(n), OW'(IN_CH+2));
    check("b2b data", o_data, vec[4].exp_data);
    check("b2b sat", OW'(o_sat), OW'(0));
    pop("b2b");

    // Reset with counter=3 in ACC, then a clean vector right after release.
    send(vec[1].data, vec[1].weight, "midrst");
    for (int c = 0; c < 3; c++) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("midrst data", o_data, '0);
    check("midrst sat", OW'(o_sat), OW'(0));
    check("midrst valid", OW'(o_out_valid), OW'(0));
    check("midrst busy", OW'(o_busy), OW'(0));
    check("midrst ready", OW'(o_in_ready), OW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    send(vec[0].data, vec[0].weight, "postrst");
    wait_valid(n);
    check("postrst latency", OW'(n), OW'(IN_CH+2));
    e = vec[0].exp_data;
    check("postrst data", o_data, e);
    check("postrst sat", OW'(o_sat), OW'(0));
    pop("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
